// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked front-end for an active-low NAND SR latch.
// Debounces set_req / reset_req, turns each debounced rising edge into a
// fixed-width low pulse on s or r, and never drives s=0 together with r=0.
// Reset wins when set and reset are requested in the same decision cycle.
// Build option: define SR_DRIVER_SYNC_EN to add a two-flop synchronizer on
// each request input ahead of the debouncers (adds two cycles of latency).
module sr_latch_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic reset_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic q_track,
  output logic conflict
);

  localparam logic [7:0] DbMax     = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] PulseLoad = 8'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPulseSet, StPulseRst, StGap} state_e;

  // Index 0 = set path, index 1 = reset path.
  logic [1:0] smp;
  logic [1:0] ev;

`ifdef SR_DRIVER_SYNC_EN
  logic [1:0] set_sync_q;
  logic [1:0] reset_sync_q;

  // Two-flop synchronizers on the raw request lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_sync_q   <= 2'b00;
      reset_sync_q <= 2'b00;
    end else begin
      set_sync_q   <= {set_sync_q[0], set_req};
      reset_sync_q <= {reset_sync_q[0], reset_req};
    end
  end

  assign smp = {reset_sync_q[1], set_sync_q[1]};
`else
  assign smp = {reset_req, set_req};
`endif

  for (genvar g = 0; g < 2; g++) begin : g_db
    logic       level_q;
    logic [7:0] cnt_q;
    logic       ev_q;

    // Debouncer: level flips on the DEBOUNCE_CYCLES-th consecutive differing
    // sample; a flip to 1 raises a one-cycle event on the following cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        level_q <= 1'b0;
        cnt_q   <= 8'd0;
        ev_q    <= 1'b0;
      end else begin
        ev_q <= 1'b0;
        if (smp[g] != level_q) begin
          if (cnt_q == DbMax) begin
            level_q <= smp[g];
            cnt_q   <= 8'd0;
            ev_q    <= smp[g];
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end else begin
          cnt_q <= 8'd0;
        end
      end
    end

    assign ev[g] = ev_q;
  end

  logic set_ev, reset_ev;
  assign set_ev   = ev[0];
  assign reset_ev = ev[1];

  state_e     state_q, state_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       set_pend_q, set_pend_d;
  logic       rst_pend_q, rst_pend_d;
  logic       s_d, r_d, busy_d, q_track_d, conflict_d;
  logic       set_any, rst_any;

  assign set_any = set_ev | set_pend_q;
  assign rst_any = reset_ev | rst_pend_q;

  // State register plus registered outputs; reset parks s/r high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pcnt_q     <= 8'd0;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
      s          <= 1'b1;
      r          <= 1'b1;
      busy       <= 1'b0;
      q_track    <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      s          <= s_d;
      r          <= r_d;
      busy       <= busy_d;
      q_track    <= q_track_d;
      conflict   <= conflict_d;
    end
  end

  // Next-state: arbitration in IDLE, pulse countdown, pending capture.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    set_pend_d = set_pend_q;
    rst_pend_d = rst_pend_q;
    unique case (state_q)
      StIdle: begin
        if (rst_any) begin
          state_d    = StPulseRst;
          pcnt_d     = PulseLoad;
          rst_pend_d = 1'b0;
          set_pend_d = 1'b0;  // a competing set is discarded
        end else if (set_any) begin
          state_d    = StPulseSet;
          pcnt_d     = PulseLoad;
          set_pend_d = 1'b0;
        end
      end
      StPulseSet, StPulseRst: begin
        if (pcnt_q == 8'd0) begin
          state_d = StGap;
        end else begin
          pcnt_d = pcnt_q - 8'd1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Events that arrive while a command is in flight are queued one-deep.
    if (state_q != StIdle) begin
      if (set_ev) begin
        set_pend_d = 1'b1;
      end
      if (reset_ev) begin
        rst_pend_d = 1'b1;
      end
    end
  end

  // Output decode from the next state so every output comes from a flop.
  always_comb begin
    s_d        = (state_d != StPulseSet);
    r_d        = (state_d != StPulseRst);
    busy_d     = (state_d != StIdle);
    q_track_d  = q_track;
    conflict_d = (state_q == StIdle) && rst_any && set_any;
    if (state_q == StIdle && state_d == StPulseSet) begin
      q_track_d = 1'b1;
    end else if (state_q == StIdle && state_d == StPulseRst) begin
      q_track_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a per-cycle expected-output queue.
// Expected vector layout: {s, r, busy, q_track, conflict}.
module tb_sr_latch_driver;

  localparam int D = 4;
  localparam int P = 2;
`ifdef SR_DRIVER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  localparam logic [4:0] Idle0  = 5'b11000;
  localparam logic [4:0] Idle1  = 5'b11010;
  localparam logic [4:0] PSet   = 5'b01110;
  localparam logic [4:0] PRst   = 5'b10100;
  localparam logic [4:0] PRstC  = 5'b10101;
  localparam logic [4:0] Gap1   = 5'b11110;
  localparam logic [4:0] Gap0   = 5'b11100;

  logic clk = 1'b0;
  logic rst, set_req, reset_req;
  logic s, r, busy, q_track, conflict;

  always #5 clk = ~clk;

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .reset_req(reset_req),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .q_track  (q_track),
    .conflict (conflict)
  );

  typedef struct {
    string      tag;
    logic [4:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [4:0] v, input int n);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    repeat (n) sb.push_back(e);
  endtask

  task automatic tick();
    exp_t       e;
    logic [4:0] obs;
    @(posedge clk);
    #1;
    obs = {s, r, busy, q_track, conflict};
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_underflow: observed=%b required=<queued entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v)
      else begin
        n_bad++;
        $error("FAIL %s: observed {s,r,busy,q,conf}=%b required=%b", e.tag, obs, e.v);
      end
    end
    n_cmp++;
    assert ((s | r) === 1'b1)
    else begin
      n_bad++;
      $error("FAIL s_or_r_invariant: observed s=%b r=%b required s|r=1", s, r);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst       = 1'b1;
    set_req   = 1'b0;
    reset_req = 1'b0;

    // Reset state
    push("reset_hold", Idle0, 2);
    run(2);
    rst = 1'b0;
    push("after_reset", Idle0, 3);
    run(3);

    // Clean set
    set_req = 1'b1;
    push("clean_wait", Idle0, 4 + L);
    push("clean_pulse", PSet, P);
    push("clean_gap", Gap1, 1);
    push("clean_idle", Idle1, 2);
    run(9 + L);
    set_req = 1'b0;
    push("clean_release", Idle1, D + L + 2);
    run(D + L + 2);

    // Bounce rejection: 1,0,1,1,0 then low
    begin
      logic [4:0] pat;
      pat = 5'b10110;
      for (int i = 4; i >= 0; i--) begin
        set_req = pat[i];
        push("bounce", Idle1, 1);
        run(1);
      end
    end
    set_req = 1'b0;
    push("bounce_settle", Idle1, 8);
    run(8);

    // Simultaneous request: reset wins, conflict strobes once
    set_req   = 1'b1;
    reset_req = 1'b1;
    push("simul_wait", Idle1, 4 + L);
    push("simul_conflict", PRstC, 1);
    push("simul_pulse", PRst, 1);
    push("simul_gap", Gap0, 1);
    push("simul_idle", Idle0, 2);
    run(9 + L);
    set_req   = 1'b0;
    reset_req = 1'b0;
    push("simul_release", Idle0, D + L + 2);
    run(D + L + 2);

    // Queued reset arriving during PULSE_SET
    set_req = 1'b1;
    push("queue_wait", Idle0, 4 + L);
    push("queue_set", PSet, 2);
    push("queue_gap1", Gap1, 1);
    push("queue_idle1", Idle1, 1);
    push("queue_rst", PRst, 2);
    push("queue_gap0", Gap0, 1);
    push("queue_idle0", Idle0, 2);
    run(1);
    reset_req = 1'b1;
    run(12 + L);
    set_req   = 1'b0;
    reset_req = 1'b0;
    push("queue_release", Idle0, D + L + 2);
    run(D + L + 2);

    // Reset during second cycle of PULSE_RST
    reset_req = 1'b1;
    push("midrst_wait", Idle0, 4 + L);
    push("midrst_pulse", PRst, 2);
    run(6 + L);
    rst = 1'b1;
    push("midrst_cut", Idle0, 1);
    run(1);
    rst       = 1'b0;
    reset_req = 1'b0;
    push("midrst_quiet", Idle0, D + L + 4);
    run(D + L + 4);

    // Reset during PULSE_SET clears q_track; held request re-fires afterwards
    set_req = 1'b1;
    push("setrst_wait", Idle0, 4 + L);
    push("setrst_pulse", PSet, 1);
    run(5 + L);
    rst = 1'b1;
    push("setrst_cut", Idle0, 1);
    run(1);
    rst = 1'b0;
    push("held_wait", Idle0, 4 + L);
    push("held_pulse", PSet, 2);
    push("held_gap", Gap1, 1);
    push("held_idle", Idle1, 2);
    run(9 + L);
    set_req = 1'b0;
    push("held_release", Idle1, D + L + 2);
    run(D + L + 2);

    n_cmp++;
    assert (sb.size() == 0)
    else begin
      n_bad++;
      $error("FAIL scoreboard_leftover: observed=%0d entries required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
